// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
//
// UART receiver front end. The asynchronous serial pin is brought into the
// clk_i domain through a two-FF synchroniser. A free-running divider produces
// the oversample tick (16 ticks per bit). The FSM aligns to the middle of the
// start bit and then samples LSB-first data bits at their midpoints. Finally
// it checks the stop bit. A low stop bit flags a framing error, and a line
// held low (break) is then swallowed until it returns high.
//
// Ports:
//   clk_i          : system clock, all logic on the rising edge
//   rst_ni         : synchronous, active-low reset
//   rx_i           : asynchronous serial line, idle high
//   data_o         : last correctly framed byte (held between frames)
//   rx_done_tick_o : one-cycle pulse, data_o newly updated
//   frame_err_o    : one-cycle pulse, stop bit sampled low, byte discarded
//   busy_o         : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_oversample #(
  parameter int DATA_BIT   = 8,
  parameter int CLK_DIV    = 54,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [DATA_BIT-1:0] data_o,
  output logic                rx_done_tick_o,
  output logic                frame_err_o,
  output logic                busy_o
);

  localparam int NW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

  // Tick indices: last tick of a bit period, and the start-bit midpoint.
  localparam logic [3:0]    S_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_HALF   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DATA_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_meta_d;
  logic                rx_s_q, rx_s_d;
  logic [15:0]         div_cnt_q, div_cnt_d;
  logic [3:0]          s_cnt_q, s_cnt_d;
  logic [NW-1:0]       n_cnt_q, n_cnt_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                s_tick;

  // The divider free-runs and is never restarted on a start edge. The
  // resulting phase uncertainty is at most one oversample tick.
  assign s_tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
    div_cnt_d = s_tick ? 16'd0 : div_cnt_q + 16'd1;

    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          s_cnt_d = 4'd0;
        end
      end
      S_START: begin
        if (s_tick) begin
          if (s_cnt_q == S_HALF) begin
            // At the start-bit midpoint the line must still be low. If it
            // is not, the edge was a glitch and is dropped silently.
            if (!rx_s_q) begin
              state_d = S_DATA;
              s_cnt_d = 4'd0;
              n_cnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = 4'd0;
            shift_d = {rx_s_q, shift_q[DATA_BIT-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = S_STOP;
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            // Leave at the stop midpoint so a back-to-back start edge
            // half a bit later is still seen from idle.
            if (rx_s_q) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_cnt_q <= 16'd0;
      s_cnt_q   <= 4'd0;
      n_cnt_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      div_cnt_q <= div_cnt_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign data_o         = data_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversample
//
// Bench for uart_rx_oversample. Instance A uses CLK_DIV=4 (64 clocks per bit)
// for the functional scenarios. Instance B uses CLK_DIV=54 (864 clocks per
// bit) for the baud-offset scenario. Expected bytes are queued when a frame
// is driven. The monitor records every received byte, and each scenario task
// compares the new observations against its queued expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b, err_a, err_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_rx_oversample #(.DATA_BIT(8), .CLK_DIV(4), .OVERSAMPLE(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .data_o(data_a),
    .rx_done_tick_o(done_a), .frame_err_o(err_a), .busy_o(busy_a)
  );

  uart_rx_oversample #(.DATA_BIT(8), .CLK_DIV(54), .OVERSAMPLE(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .data_o(data_b),
    .rx_done_tick_o(done_b), .frame_err_o(err_b), .busy_o(busy_b)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: counts pulses and logs received bytes with their cycle stamp.
  int         done_cnt_a = 0, err_cnt_a = 0, done_cnt_b = 0, err_cnt_b = 0;
  logic [7:0] obs_a[$], obs_b[$];
  int         obs_cyc_a[$];
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt_a++;
      obs_a.push_back(data_a);
      obs_cyc_a.push_back(cyc);
    end
    if (err_a) err_cnt_a++;
    if (done_b) begin
      done_cnt_b++;
      obs_b.push_back(data_b);
    end
    if (err_b) err_cnt_b++;
  end

  // Scoreboard expectations, written only by the stimulus process.
  logic [7:0] exp_a[$], exp_b[$];
  int         rd_a = 0, rd_b = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Start bit, 8 data bits LSB first, and the stop bit. The line is left at
  // the stop level.
  task automatic send_frame(input bit sel, input logic [7:0] b, input int bitc,
                            input logic stop);
    drive(sel, 1'b0);
    tick(bitc);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      tick(bitc);
    end
    drive(sel, stop);
    tick(bitc);
  endtask

  task automatic test_reset;
    checks++;
    if ({data_a, done_a, err_a, busy_a} !== 11'd0) begin
      errors++;
      $display("FAIL reset_a outputs=%03h required=000", {data_a, done_a, err_a, busy_a});
    end
    checks++;
    if ({data_b, done_b, err_b, busy_b} !== 11'd0) begin
      errors++;
      $display("FAIL reset_b outputs=%03h required=000", {data_b, done_b, err_b, busy_b});
    end
    rst_n = 1'b1;
    tick(10);
    $display("test_reset done");
  endtask

  task automatic test_single;
    int d0, e0;
    logic [7:0] e;
    d0 = done_cnt_a; e0 = err_cnt_a;
    exp_a.push_back(8'h55);
    send_frame(1'b0, 8'h55, 64, 1'b1);
    tick(64);
    checks++;
    if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL single_done got=%0d required=1", done_cnt_a - d0); end
    checks++;
    if (err_cnt_a - e0 !== 0) begin errors++; $display("FAIL single_err got=%0d required=0", err_cnt_a - e0); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy got=%b required=0", busy_a); end
    checks++;
    if (data_a !== 8'h55) begin errors++; $display("FAIL single_data got=%02h required=55", data_a); end
    checks++;
    if (obs_a.size() - rd_a !== exp_a.size()) begin errors++; $display("FAIL single_sb_count got=%0d required=%0d", obs_a.size() - rd_a, exp_a.size()); end
    while (exp_a.size() > 0 && rd_a < obs_a.size()) begin
      checks++; e = exp_a.pop_front();
      if (obs_a[rd_a] !== e) begin errors++; $display("FAIL single_sb got=%02h required=%02h", obs_a[rd_a], e); end
      rd_a++;
    end
    exp_a.delete(); rd_a = obs_a.size();
    $display("test_single byte=%02h done", data_a);
  endtask

  task automatic test_back_to_back;
    int d0, e0, n, gap;
    logic [7:0] e;
    d0 = done_cnt_a; e0 = err_cnt_a;
    exp_a.push_back(8'hA3);
    exp_a.push_back(8'h0F);
    send_frame(1'b0, 8'hA3, 64, 1'b1);
    send_frame(1'b0, 8'h0F, 64, 1'b1);
    tick(64);
    checks++;
    if (done_cnt_a - d0 !== 2) begin errors++; $display("FAIL b2b_done got=%0d required=2", done_cnt_a - d0); end
    checks++;
    if (err_cnt_a - e0 !== 0) begin errors++; $display("FAIL b2b_err got=%0d required=0", err_cnt_a - e0); end
    n = obs_cyc_a.size();
    gap = (n >= 2) ? obs_cyc_a[n-1] - obs_cyc_a[n-2] : 0;
    checks++;
    if (gap < 636 || gap > 644) begin errors++; $display("FAIL b2b_gap got=%0d required=636..644", gap); end
    checks++;
    if (data_a !== 8'h0F) begin errors++; $display("FAIL b2b_data got=%02h required=0f", data_a); end
    checks++;
    if (obs_a.size() - rd_a !== exp_a.size()) begin errors++; $display("FAIL b2b_sb_count got=%0d required=%0d", obs_a.size() - rd_a, exp_a.size()); end
    while (exp_a.size() > 0 && rd_a < obs_a.size()) begin
      checks++; e = exp_a.pop_front();
      if (obs_a[rd_a] !== e) begin errors++; $display("FAIL b2b_sb got=%02h required=%02h", obs_a[rd_a], e); end
      rd_a++;
    end
    exp_a.delete(); rd_a = obs_a.size();
    $display("test_back_to_back gap=%0d done", gap);
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt_a; e0 = err_cnt_a;
    drive(1'b0, 1'b0);
    tick(10);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got=%b required=1", busy_a); end
    tick(10);
    drive(1'b0, 1'b1);
    tick(60);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo got=%b required=0", busy_a); end
    checks++;
    if ((done_cnt_a - d0) + (err_cnt_a - e0) !== 0) begin
      errors++; $display("FAIL glitch_pulses got=%0d required=0", (done_cnt_a - d0) + (err_cnt_a - e0));
    end
    checks++;
    if (data_a !== 8'h0F) begin errors++; $display("FAIL glitch_data got=%02h required=0f", data_a); end
    $display("test_glitch done");
  endtask

  task automatic test_framing;
    int d0, e0;
    logic [7:0] e;
    d0 = done_cnt_a; e0 = err_cnt_a;
    send_frame(1'b0, 8'h3C, 64, 1'b0);
    tick(2000);
    checks++;
    if (err_cnt_a - e0 !== 1) begin errors++; $display("FAIL frame_err got=%0d required=1", err_cnt_a - e0); end
    checks++;
    if (done_cnt_a - d0 !== 0) begin errors++; $display("FAIL frame_done got=%0d required=0", done_cnt_a - d0); end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL frame_break_busy got=%b required=1", busy_a); end
    checks++;
    if (data_a !== 8'h0F) begin errors++; $display("FAIL frame_data_kept got=%02h required=0f", data_a); end
    drive(1'b0, 1'b1);
    tick(64);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL frame_release_busy got=%b required=0", busy_a); end
    exp_a.push_back(8'h81);
    send_frame(1'b0, 8'h81, 64, 1'b1);
    tick(64);
    checks++;
    if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL frame_recover_done got=%0d required=1", done_cnt_a - d0); end
    checks++;
    if (err_cnt_a - e0 !== 1) begin errors++; $display("FAIL frame_recover_err got=%0d required=1", err_cnt_a - e0); end
    checks++;
    if (data_a !== 8'h81) begin errors++; $display("FAIL frame_recover_data got=%02h required=81", data_a); end
    checks++;
    if (obs_a.size() - rd_a !== exp_a.size()) begin errors++; $display("FAIL frame_sb_count got=%0d required=%0d", obs_a.size() - rd_a, exp_a.size()); end
    while (exp_a.size() > 0 && rd_a < obs_a.size()) begin
      checks++; e = exp_a.pop_front();
      if (obs_a[rd_a] !== e) begin errors++; $display("FAIL frame_sb got=%02h required=%02h", obs_a[rd_a], e); end
      rd_a++;
    end
    exp_a.delete(); rd_a = obs_a.size();
    $display("test_framing done");
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [7:0] e;
    d0 = done_cnt_a; e0 = err_cnt_a;
    // Frame 0xF0: bits 4..7 are high, so after the abort the line stays high.
    drive(1'b0, 1'b0); tick(64);
    drive(1'b0, 1'b0); tick(4 * 64);
    drive(1'b0, 1'b1); tick(32);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if ({data_a, done_a, err_a, busy_a} !== 11'd0) begin
      errors++; $display("FAIL midreset_outputs got=%03h required=000", {data_a, done_a, err_a, busy_a});
    end
    tick(31 + 3 * 64 + 64 + 64);
    checks++;
    if ((done_cnt_a - d0) + (err_cnt_a - e0) !== 0) begin
      errors++; $display("FAIL midreset_pulses got=%0d required=0", (done_cnt_a - d0) + (err_cnt_a - e0));
    end
    exp_a.push_back(8'hC6);
    send_frame(1'b0, 8'hC6, 64, 1'b1);
    tick(64);
    checks++;
    if (data_a !== 8'hC6) begin errors++; $display("FAIL midreset_data got=%02h required=c6", data_a); end
    checks++;
    if (obs_a.size() - rd_a !== exp_a.size()) begin errors++; $display("FAIL midreset_sb_count got=%0d required=%0d", obs_a.size() - rd_a, exp_a.size()); end
    while (exp_a.size() > 0 && rd_a < obs_a.size()) begin
      checks++; e = exp_a.pop_front();
      if (obs_a[rd_a] !== e) begin errors++; $display("FAIL midreset_sb got=%02h required=%02h", obs_a[rd_a], e); end
      rd_a++;
    end
    exp_a.delete(); rd_a = obs_a.size();
    $display("test_reset_mid done");
  endtask

  task automatic test_baud_offset;
    int d0, e0;
    logic [7:0] e;
    d0 = done_cnt_b; e0 = err_cnt_b;
    exp_b.push_back(8'h00); send_frame(1'b1, 8'h00, 890, 1'b1); tick(864);
    exp_b.push_back(8'hFF); send_frame(1'b1, 8'hFF, 838, 1'b1); tick(864);
    exp_b.push_back(8'h00); send_frame(1'b1, 8'h00, 838, 1'b1); tick(864);
    exp_b.push_back(8'hFF); send_frame(1'b1, 8'hFF, 890, 1'b1); tick(864);
    checks++;
    if (done_cnt_b - d0 !== 4) begin errors++; $display("FAIL baud_done got=%0d required=4", done_cnt_b - d0); end
    checks++;
    if (err_cnt_b - e0 !== 0) begin errors++; $display("FAIL baud_err got=%0d required=0", err_cnt_b - e0); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL baud_busy got=%b required=0", busy_b); end
    checks++;
    if (obs_b.size() - rd_b !== exp_b.size()) begin errors++; $display("FAIL baud_sb_count got=%0d required=%0d", obs_b.size() - rd_b, exp_b.size()); end
    while (exp_b.size() > 0 && rd_b < obs_b.size()) begin
      checks++; e = exp_b.pop_front();
      if (obs_b[rd_b] !== e) begin errors++; $display("FAIL baud_sb got=%02h required=%02h", obs_b[rd_b], e); end
      rd_b++;
    end
    exp_b.delete(); rd_b = obs_b.size();
    $display("test_baud_offset done");
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    tick(5);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_reset_mid;
    test_baud_offset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receiver front end that turns the asynchronous serial line into bytes for the frequency-pattern decoder and serial-output bank.
- It drives that stage's `data_i` and `rx_done_tick_i` directly.
- It synchronises the pin, generates an oversampling tick, and aligns to the middle of the start bit. It then shifts in LSB-first data and checks the stop bit.
- Framing errors are flagged. Line breaks are swallowed without producing bytes.

Parameters:
- DATA_BIT, 8: data bits per frame, LSB first.
- CLK_DIV, 54: clk_i cycles per oversample tick (clock / (16 × baud)). Legal range is 2..65535.
- OVERSAMPLE, 16: oversample ticks per bit. Fixed at 16; other values are not supported.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- rx_i  in  1  asynchronous serial line, idle high.
- data_o  out  DATA_BIT  last correctly framed byte.
- rx_done_tick_o  out  1  one-cycle pulse: data_o valid and newly updated.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- busy_o  out  1  high whenever the FSM is not in S_IDLE.

Behaviour:

Clock and reset:
- One clock. Reset is synchronous and active-low. All state is sampled only on the clk_i rising edge while rst_ni = 0.
- Reset values:
  - state = S_IDLE
  - sync FFs = 1
  - div_cnt = 0, s_cnt = 0, n_cnt = 0
  - shift register = 0
  - data_o = 0
  - rx_done_tick_o = 0, frame_err_o = 0, busy_o = 0
- Reset mid-frame aborts the frame with no pulse of either kind.

Synchroniser:
- Two-FF synchroniser on rx_i. rx_s is the second FF output.
- All FSM decisions use rx_s only, so there are 2 cycles of input latency.

Tick generator:
- div_cnt is free-running 0..CLK_DIV-1 and wraps to 0.
- s_tick = 1 for the single cycle when div_cnt == CLK_DIV-1.
- div_cnt is not reset on start detection. Alignment jitter is ≤ 1 tick.

FSM states:
- S_IDLE:
  - rx_s == 0 → S_START, s_cnt = 0.
- S_START, advances only on s_tick:
  - s_cnt == 7 and rx_s == 0 → S_DATA, s_cnt = 0, n_cnt = 0.
  - s_cnt == 7 and rx_s == 1 → S_IDLE. This is glitch rejection: no pulse.
  - Otherwise s_cnt++.
- S_DATA, on s_tick:
  - s_cnt == 15: s_cnt = 0 and shift = {rx_s, shift[DATA_BIT-1:1]}.
    - If n_cnt == DATA_BIT-1 → S_STOP, otherwise n_cnt++.
  - Otherwise s_cnt++.
- S_STOP, on s_tick:
  - s_cnt == 15 samples the stop bit at its middle.
    - rx_s == 1: data_o ← shift, rx_done_tick_o = 1 on the next cycle, → S_IDLE.
    - rx_s == 0: frame_err_o = 1 on the next cycle, data_o unchanged, → S_BREAK.
  - Otherwise s_cnt++.
- S_BREAK:
  - Stay while rx_s == 0; rx_s == 1 → S_IDLE.
  - A held-low line (break) yields exactly one frame_err_o pulse and no further bytes.

Outputs:
- rx_done_tick_o and frame_err_o are registered and mutually exclusive. Each is high exactly one clk_i cycle per frame.
- busy_o is registered from the next state. It is 0 in S_IDLE and 1 in every other state, including S_BREAK.
- data_o holds its value between frames.

Back-to-back frames:
- A new start bit may begin immediately after the stop-bit midpoint.
- S_IDLE is re-entered in time to detect a falling edge half a bit later.

Test Plan:
1. CLK_DIV = 4 (bit = 64 clks). Send 0x55 with a good stop bit.
   → rx_done_tick_o is a single pulse; data_o = 0x55; frame_err_o stays 0; busy_o = 0 afterwards.
2. Send 0xA3 then 0x0F back-to-back, no idle gap.
   → Two rx_done_tick_o pulses ~640 clks apart; data_o = 0xA3 then 0x0F.
3. 20-clk low glitch on an idle line.
   → No pulses; busy_o returns to 0 after the start-bit check at tick 7; data_o unchanged.
4. Send 0x3C with the stop bit forced low.
   → One frame_err_o pulse; data_o keeps its previous value; FSM remains in S_BREAK.
   - Hold the line low for 2000 clks → no further pulses.
   - Release the line, then send 0x81 → data_o = 0x81.
5. Assert rst_ni = 0 for 1 cycle during data bit 4 of a frame.
   → All outputs reset to 0 at that edge; no pulse for the aborted frame.
   - A subsequent clean frame of 0xC6 is received correctly.
6. CLK_DIV = 54 with the baud rate offset ±3%, sending 0x00 and 0xFF.
   → Both bytes are received correctly with no frame_err_o.
